// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - two-stage elastic RV immediate generator with opcode-derived format
// Optional feature macro: IMMGEN_SHAMT_EN (shift opcodes decode to fmt 101 with a zero-extended shamt)
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [15:0]      illegal_cnt
);

    localparam logic [2:0] FMT_I     = 3'b000;
    localparam logic [2:0] FMT_S     = 3'b001;
    localparam logic [2:0] FMT_B     = 3'b010;
    localparam logic [2:0] FMT_U     = 3'b011;
    localparam logic [2:0] FMT_J     = 3'b100;
`ifdef IMMGEN_SHAMT_EN
    localparam logic [2:0] FMT_SHAMT = 3'b101;
`endif
    localparam logic [2:0] FMT_NONE  = 3'b111;
    localparam bit         IS_RV64   = (XLEN == 64);

    logic             s1_valid;
    logic [31:0]      s1_instr;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic [15:0]      cnt_q;

    logic             in_fire;
    logic             s1_adv;
    logic             out_fire;

    // Immediates are built at 64 bits and truncated, so XLEN=32 needs no zero-width replication.
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [63:0] dec_imm;
    logic [2:0]  dec_fmt;
    logic        dec_ill;

    assign imm_i = {{52{s1_instr[31]}}, s1_instr[31:20]};
    assign imm_s = {{52{s1_instr[31]}}, s1_instr[31:25], s1_instr[11:7]};
    assign imm_b = {{51{s1_instr[31]}}, s1_instr[31], s1_instr[7], s1_instr[30:25],
                    s1_instr[11:8], 1'b0};
    assign imm_u = {{32{s1_instr[31]}}, s1_instr[31:12], 12'b0};
    assign imm_j = {{43{s1_instr[31]}}, s1_instr[31], s1_instr[19:12], s1_instr[20],
                    s1_instr[30:21], 1'b0};

    always_comb begin
        dec_imm = 64'd0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        case (s1_instr[6:0])
            7'b0000011, 7'b1100111: begin
                dec_imm = imm_i;
                dec_fmt = FMT_I;
            end
            7'b0010011: begin
                dec_imm = imm_i;
                dec_fmt = FMT_I;
`ifdef IMMGEN_SHAMT_EN
                if (s1_instr[13:12] == 2'b01) begin
                    dec_fmt = FMT_SHAMT;
                    dec_imm = IS_RV64 ? {58'd0, s1_instr[25:20]} : {59'd0, s1_instr[24:20]};
                end
`endif
            end
            7'b0011011: begin
                if (IS_RV64) begin
                    dec_imm = imm_i;
                    dec_fmt = FMT_I;
`ifdef IMMGEN_SHAMT_EN
                    // slli.uw carries a 6-bit shamt; the other word shifts only 5 bits.
                    if (s1_instr[14:12] == 3'b001 && s1_instr[31:26] == 6'b000010) begin
                        dec_fmt = FMT_SHAMT;
                        dec_imm = {58'd0, s1_instr[25:20]};
                    end else if (s1_instr[13:12] == 2'b01) begin
                        dec_fmt = FMT_SHAMT;
                        dec_imm = {59'd0, s1_instr[24:20]};
                    end
`endif
                end else begin
                    dec_ill = 1'b1;
                end
            end
            7'b0100011: begin
                dec_imm = imm_s;
                dec_fmt = FMT_S;
            end
            7'b1100011: begin
                dec_imm = imm_b;
                dec_fmt = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm = imm_u;
                dec_fmt = FMT_U;
            end
            7'b1101111: begin
                dec_imm = imm_j;
                dec_fmt = FMT_J;
            end
            7'b0110011: dec_ill = 1'b0;
            7'b0111011: dec_ill = !IS_RV64;
            default:    dec_ill = 1'b1;
        endcase
    end

    assign in_ready    = !rst && !flush && (!s1_valid || !s2_valid || out_ready);
    assign in_fire     = in_valid && in_ready;
    assign s1_adv      = s1_valid && (!s2_valid || out_ready);
    assign out_valid   = s2_valid;
    assign out_fire    = s2_valid && out_ready && !flush;
    assign illegal_cnt = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_instr    <= 32'd0;
            s1_tag      <= '0;
            s2_valid    <= 1'b0;
            out_imm     <= '0;
            out_fmt     <= FMT_NONE;
            out_tag     <= '0;
            out_illegal <= 1'b0;
            cnt_q       <= 16'd0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_instr <= in_instr;
                s1_tag   <= in_tag;
            end
            s1_valid <= in_fire || (s1_valid && !s1_adv);
            // S2 only loads from a valid S1, so a bubble never overwrites a stalled result.
            if (s1_adv) begin
                out_imm     <= dec_imm[XLEN-1:0];
                out_fmt     <= dec_fmt;
                out_tag     <= s1_tag;
                out_illegal <= dec_ill;
            end
            s2_valid <= s1_adv || (s2_valid && !out_ready);
            if (out_fire && out_illegal && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [3:0]  out_tag;
    logic        out_illegal;
    logic [15:0] illegal_cnt;

    int checks = 0;
    int errors = 0;

    imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_tag(out_tag), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one instruction into an empty pipe and check it appears after exactly two edges.
    task automatic run_one(input string name, input logic [31:0] ins, input logic [3:0] tg,
                           input logic [63:0] eimm, input logic [2:0] efmt, input logic eill);
        @(negedge clk);
        in_valid = 1'b1; in_instr = ins; in_tag = tg; out_ready = 1'b1;
        #1 chk({name, "_in_ready"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, "_early"}, out_valid, 1'b0);
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_imm"}, out_imm, eimm);
        chk({name, "_fmt"}, out_fmt, efmt);
        chk({name, "_ill"}, out_illegal, eill);
        chk({name, "_tag"}, out_tag, tg);
        @(negedge clk);
    endtask

    // Stream n copies with out_ready=1 and check each result's format and illegal flag.
    task automatic stream(input string name, input logic [31:0] ins, input int n,
                          input logic [2:0] efmt, input logic eill);
        int sent = 0;
        int got = 0;
        for (int cyc = 0; cyc < 50 && got < n; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1; in_instr = ins; in_tag = sent[3:0];
            in_valid = (sent < n);
            #1;
            if (in_valid && in_ready) sent++;
            if (out_valid) begin
                chk({name, "_fmt"}, out_fmt, efmt);
                chk({name, "_ill"}, out_illegal, eill);
                got++;
            end
        end
        in_valid = 1'b0;
        chk({name, "_count"}, got, n);
        @(negedge clk);
    endtask

    initial begin
        int nxt;
        int exp_tag;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_tag = 4'd0;
        out_ready = 1'b0;
        #3;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_imm", out_imm, 64'd0);
        chk("rst_fmt", out_fmt, 3'b111);
        chk("rst_tag", out_tag, 4'd0);
        chk("rst_ill", out_illegal, 1'b0);
        chk("rst_cnt", illegal_cnt, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", in_ready, 1'b1);

        run_one("addi", 32'hFFF00093, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1'b0);
        run_one("lui",  32'h800000B7, 4'd2, 64'hFFFF_FFFF_8000_0000, 3'b011, 1'b0);
        run_one("jal",  32'hFFFFF0EF, 4'd3, 64'hFFFF_FFFF_FFFF_FFFE, 3'b100, 1'b0);
        run_one("beq",  32'hFE000EE3, 4'd4, 64'hFFFF_FFFF_FFFF_FFFC, 3'b010, 1'b0);
        run_one("sw",   32'hFE112E23, 4'd5, 64'hFFFF_FFFF_FFFF_FFFC, 3'b001, 1'b0);
        run_one("add",  32'h00208033, 4'd6, 64'd0, 3'b111, 1'b0);
        run_one("addw", 32'h0000003B, 4'd7, 64'd0, 3'b111, 1'b0);
`ifdef IMMGEN_SHAMT_EN
        run_one("slliuw", 32'h0A81109B, 4'd8, 64'd40, 3'b101, 1'b0);
        run_one("slli",   32'h03F09093, 4'd9, 64'd63, 3'b101, 1'b0);
`else
        run_one("slliuw", 32'h0A81109B, 4'd8, 64'hA8, 3'b000, 1'b0);
        run_one("slli",   32'h03F09093, 4'd9, 64'h3F, 3'b000, 1'b0);
`endif

        // Backpressure: out_ready low for the first 5 cycles, tags 0..3 must emerge in order.
        nxt = 0;
        exp_tag = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid = (nxt < 4);
            in_tag = nxt[3:0];
            in_instr = {nxt[11:0], 20'h00093};
            #1;
            if (cyc == 4) begin
                chk("bp_accepts", nxt, 2);
                chk("bp_in_ready", in_ready, 1'b0);
            end
            if (in_valid && in_ready) nxt++;
            if (out_valid && out_ready) begin
                chk("bp_tag", out_tag, exp_tag[3:0]);
                chk("bp_imm", out_imm, exp_tag);
                exp_tag++;
            end
        end
        in_valid = 1'b0;
        chk("bp_total", exp_tag, 4);

        stream("illegal", 32'h0000007F, 3, 3'b111, 1'b1);
        chk("cnt_after_3", illegal_cnt, 16'd3);

        // Flush with two held illegal instructions: nothing is counted, nothing is accepted.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000007F; in_tag = 4'hA;
        end
        @(negedge clk);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        chk("flush_pre_valid", out_valid, 1'b1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_cnt", illegal_cnt, 16'd3);
        @(negedge clk);
        chk("flush_no_accept", out_valid, 1'b0);
        chk("flush_cnt2", illegal_cnt, 16'd3);

        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        chk("preload", illegal_cnt, 16'hFFFE);
        stream("sat", 32'h0000007F, 3, 3'b111, 1'b1);
        chk("cnt_sat", illegal_cnt, 16'hFFFF);

        // Asynchronous reset between edges while a result is held.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000007F; in_tag = 4'h3;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("ar_pre_valid", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_cnt", illegal_cnt, 16'd0);
        chk("ar_in_ready", in_ready, 1'b0);
        chk("ar_fmt", out_fmt, 3'b111);
        @(negedge clk);
        rst = 1'b0;
        run_one("post_ar", 32'hFFF00093, 4'hC, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

endmodule
